// File: rtl/dsc_mul_seq_if.sv
// ---------------------------------------------------------------------------
// dsc_mul_seq_if
// Operand/result handshake bundle for the dsc_mul_seq controller.
//   in_valid / in_ready : operand triple handshake (source -> controller)
//   a, b, c             : W-bit operands, sampled on accept
//   out_valid/out_ready : result handshake (controller -> consumer)
//   z                   : 3W-bit product count
// Modports:
//   master : operand source / result consumer side
//   slave  : controller side
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface dsc_mul_seq_if #(
  parameter int W = 10
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [W-1:0]   c;
  logic           out_valid;
  logic           out_ready;
  logic [3*W-1:0] z;

  modport master (
    output in_valid, a, b, c, out_ready,
    input  in_ready, out_valid, z
  );

  modport slave (
    input  in_valid, a, b, c, out_ready,
    output in_ready, out_valid, z
  );
endinterface

// File: rtl/dsc_mul_seq.sv
// ---------------------------------------------------------------------------
// dsc_mul_seq
// Sequencer for a 3-input deterministic stochastic-computing multiplier
// datapath. Accepts an operand triple, holds it on dp_a/b/c, clears the
// datapath, enables it for exactly 2^(3W) clocks, then captures the product
// count and presents it on the result handshake. With ZERO_SKIP set, a zero
// operand bypasses the run and returns z=0 immediately.
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   bus (slave)       : in_valid/in_ready/a/b/c, out_valid/out_ready/z
//   err               : sticky, a run ended with no datapath overflow pulse
//   busy              : high whenever the FSM is not idle
//   dp_a, dp_b, dp_c  : operands to the datapath, stable for the whole run
//   dp_clr            : one-cycle synchronous clear to the datapath
//   dp_en             : datapath enable, high for 2^(3W) cycles per run
//   dp_z              : datapath result count
//   dp_ov             : datapath final-stage overflow pulse
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module dsc_mul_seq #(
  parameter int W         = 10,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  dsc_mul_seq_if.slave   bus,
  output logic           err,
  output logic           busy,
  output logic [W-1:0]   dp_a,
  output logic [W-1:0]   dp_b,
  output logic [W-1:0]   dp_c,
  output logic           dp_clr,
  output logic           dp_en,
  input  logic [3*W-1:0] dp_z,
  input  logic           dp_ov
);

  localparam int RW = 3 * W;
  localparam logic [RW-1:0] RC_LAST = '1;
  localparam logic [RW-1:0] RC_ONE  = {{(RW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, HOLD} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rc_q, rc_d;
  logic [RW-1:0] z_q, z_d;
  logic [W-1:0]  dp_a_q, dp_a_d;
  logic [W-1:0]  dp_b_q, dp_b_d;
  logic [W-1:0]  dp_c_q, dp_c_d;
  logic          err_q, err_d;
  logic          ov_seen_q, ov_seen_d;

  logic accept;
  logic any_zero;

  assign accept   = (state_q == IDLE) && bus.in_valid;
  assign any_zero = (bus.a == '0) || (bus.b == '0) || (bus.c == '0);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rc_q      <= '0;
      z_q       <= '0;
      dp_a_q    <= '0;
      dp_b_q    <= '0;
      dp_c_q    <= '0;
      err_q     <= 1'b0;
      ov_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rc_q      <= rc_d;
      z_q       <= z_d;
      dp_a_q    <= dp_a_d;
      dp_b_q    <= dp_b_d;
      dp_c_q    <= dp_c_d;
      err_q     <= err_d;
      ov_seen_q <= ov_seen_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (ZERO_SKIP && any_zero) state_d = HOLD;
          else                       state_d = CLEAR;
        end
      end
      CLEAR: state_d = RUN;
      // The cycle in which rc_q is all-ones is the last enabled cycle.
      RUN: begin
        if (rc_q == RC_LAST) state_d = DRAIN;
      end
      DRAIN: state_d = HOLD;
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, run counter, result capture and overflow bookkeeping
  always_comb begin
    rc_d      = rc_q;
    z_d       = z_q;
    dp_a_d    = dp_a_q;
    dp_b_d    = dp_b_q;
    dp_c_d    = dp_c_q;
    err_d     = err_q;
    ov_seen_d = ov_seen_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          dp_a_d = bus.a;
          dp_b_d = bus.b;
          dp_c_d = bus.c;
          if (ZERO_SKIP && any_zero) z_d = '0;
        end
      end
      CLEAR: begin
        rc_d      = '0;
        ov_seen_d = 1'b0;
      end
      // rc wraps to zero on the final increment.
      RUN: begin
        rc_d = rc_q + RC_ONE;
        if (dp_ov) ov_seen_d = 1'b1;
      end
      // dp_ov is also checked live here so a pulse landing in DRAIN counts.
      DRAIN: begin
        z_d = dp_z;
        if (dp_ov) ov_seen_d = 1'b1;
        if (!ov_seen_q && !dp_ov) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == HOLD);
    dp_clr        = (state_q == CLEAR);
    dp_en         = (state_q == RUN);
    busy          = (state_q != IDLE);
  end

  assign bus.z = z_q;
  assign err   = err_q;
  assign dp_a  = dp_a_q;
  assign dp_b  = dp_b_q;
  assign dp_c  = dp_c_q;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_dsc_mul_seq
// Directed bench for dsc_mul_seq at W=4. Two controllers are instantiated,
// one with ZERO_SKIP=1 and one with ZERO_SKIP=0, each driving its own
// behavioural datapath: a 3W-bit counter whose three W-bit fields act as
// deterministic SNG references, so the accumulated count equals a*b*c.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dsc_mul_seq;

  localparam int W     = 4;
  localparam int RW    = 3 * W;
  localparam int LIMIT = 6000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dsc_mul_seq_if #(.W(W)) bus0 ();
  dsc_mul_seq_if #(.W(W)) bus1 ();

  logic [1:0]   in_valid_t = '0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [W-1:0] op_c = '0;
  logic         out_ready_t = 1'b1;
  logic         suppress_ov = 1'b0;

  assign bus0.in_valid  = in_valid_t[0];
  assign bus1.in_valid  = in_valid_t[1];
  assign bus0.a         = op_a;
  assign bus0.b         = op_b;
  assign bus0.c         = op_c;
  assign bus1.a         = op_a;
  assign bus1.b         = op_b;
  assign bus1.c         = op_c;
  assign bus0.out_ready = out_ready_t;
  assign bus1.out_ready = out_ready_t;

  logic [1:0]    err_w, busy_w, dp_clr_w, dp_en_w, dp_ov_m;
  logic [W-1:0]  dp_a_w [2];
  logic [W-1:0]  dp_b_w [2];
  logic [W-1:0]  dp_c_w [2];
  logic [RW-1:0] dp_z_m [2];
  logic [RW-1:0] cnt_m  [2];

  dsc_mul_seq #(.W(W), .ZERO_SKIP(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .err(err_w[0]), .busy(busy_w[0]),
    .dp_a(dp_a_w[0]), .dp_b(dp_b_w[0]), .dp_c(dp_c_w[0]),
    .dp_clr(dp_clr_w[0]), .dp_en(dp_en_w[0]),
    .dp_z(dp_z_m[0]), .dp_ov(dp_ov_m[0])
  );

  dsc_mul_seq #(.W(W), .ZERO_SKIP(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .err(err_w[1]), .busy(busy_w[1]),
    .dp_a(dp_a_w[1]), .dp_b(dp_b_w[1]), .dp_c(dp_c_w[1]),
    .dp_clr(dp_clr_w[1]), .dp_en(dp_en_w[1]),
    .dp_z(dp_z_m[1]), .dp_ov(dp_ov_m[1])
  );

  // SNG bits are 1 while the matching counter field is below the operand;
  // sweeping every field combination yields exactly a*b*c coincidences.
  function automatic logic sng_hit(input logic [RW-1:0] n, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [W-1:0] c);
    return (n[W-1:0] < a) && (n[2*W-1:W] < b) && (n[3*W-1:2*W] < c);
  endfunction

  // Behavioural datapath for both controllers
  always @(posedge clk or negedge rst_n) begin
    for (int s = 0; s < 2; s++) begin
      if (!rst_n) begin
        cnt_m[s]  <= '0;
        dp_z_m[s] <= '0;
      end else if (dp_clr_w[s]) begin
        cnt_m[s]  <= '0;
        dp_z_m[s] <= '0;
      end else if (dp_en_w[s]) begin
        cnt_m[s]  <= cnt_m[s] + 1'b1;
        if (sng_hit(cnt_m[s], dp_a_w[s], dp_b_w[s], dp_c_w[s]))
          dp_z_m[s] <= dp_z_m[s] + 1'b1;
      end
    end
  end

  // Final-stage overflow pulses on the last enabled count unless suppressed
  always_comb begin
    dp_ov_m = '0;
    for (int s = 0; s < 2; s++)
      dp_ov_m[s] = dp_en_w[s] && (cnt_m[s] == '1) && !suppress_ov;
  end

  // Enable/clear activity monitors
  int   en_total [2];
  int   clr_total [2];
  int   overlap_cnt = 0;
  int   order_bad = 0;
  logic [1:0] armed = '0;
  logic [1:0] ovalid_w;
  assign ovalid_w = {bus1.out_valid, bus0.out_valid};

  initial begin
    for (int s = 0; s < 2; s++) begin
      en_total[s]  = 0;
      clr_total[s] = 0;
    end
  end

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (dp_en_w[s]) en_total[s] = en_total[s] + 1;
      if (dp_en_w[s] && !armed[s]) order_bad = order_bad + 1;
      if (dp_en_w[s] && dp_clr_w[s]) overlap_cnt = overlap_cnt + 1;
      if (dp_clr_w[s]) begin
        clr_total[s] = clr_total[s] + 1;
        armed[s] = 1'b1;
      end
      if (ovalid_w[s]) armed[s] = 1'b0;
    end
  end

  // Observation mux onto the instance under test
  int sel = 0;
  logic          obs_valid, obs_ready, obs_err, obs_busy, obs_en;
  logic [RW-1:0] obs_z;
  logic [W-1:0]  obs_dp_a;
  always_comb begin
    obs_valid = (sel == 1) ? bus1.out_valid : bus0.out_valid;
    obs_ready = (sel == 1) ? bus1.in_ready  : bus0.in_ready;
    obs_z     = (sel == 1) ? bus1.z         : bus0.z;
    obs_err   = err_w[sel[0]];
    obs_busy  = busy_w[sel[0]];
    obs_en    = dp_en_w[sel[0]];
    obs_dp_a  = dp_a_w[sel[0]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one triple, then keep in_valid high with scrambled operands until
  // the result appears; lat counts cycles from the accept edge.
  task automatic applyStimulus(input int s, input logic [W-1:0] ta, input logic [W-1:0] tb2,
                               input logic [W-1:0] tc, output int lat, output int en_n,
                               output int clr_n);
    int en0;
    int clr0;
    sel = s;
    @(negedge clk);
    for (int g = 0; g < 100 && !obs_ready; g++) @(negedge clk);
    en0  = en_total[s];
    clr0 = clr_total[s];
    op_a = ta;
    op_b = tb2;
    op_c = tc;
    in_valid_t[s] = 1'b1;
    @(posedge clk);
    #1;
    op_a = ~ta;
    op_b = ~tb2;
    op_c = ~tc;
    lat = 1;
    while (!obs_valid && lat < LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid_t[s] = 1'b0;
    en_n  = en_total[s] - en0;
    clr_n = clr_total[s] - clr0;
  endtask

  int lat, en_n, clr_n;

  initial begin
    sel = 0;
    #12;
    checkOutput("rst_busy",      32'(obs_busy), 32'd0);
    checkOutput("rst_in_ready",  32'(obs_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(obs_valid), 32'd0);
    checkOutput("rst_dp_en",     32'(obs_en), 32'd0);
    checkOutput("rst_dp_clr",    32'(dp_clr_w[0]), 32'd0);
    checkOutput("rst_z",         32'(obs_z), 32'd0);
    checkOutput("rst_err",       32'(obs_err), 32'd0);
    checkOutput("rst_dp_a",      32'(obs_dp_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] 8*8*8");
    applyStimulus(0, 4'd8, 4'd8, 4'd8, lat, en_n, clr_n);
    checkOutput("lat_888",  32'(lat), 32'd4099);
    checkOutput("z_888",    32'(obs_z), 32'd512);
    checkOutput("err_888",  32'(obs_err), 32'd0);
    checkOutput("en_888",   32'(en_n), 32'd4096);
    checkOutput("clr_888",  32'(clr_n), 32'd1);
    checkOutput("dpa_888",  32'(obs_dp_a), 32'd8);

    $display("[TB] 15*15*15");
    applyStimulus(0, 4'd15, 4'd15, 4'd15, lat, en_n, clr_n);
    checkOutput("z_fff",   32'(obs_z), 32'd3375);
    checkOutput("en_fff",  32'(en_n), 32'd4096);
    checkOutput("clr_fff", 32'(clr_n), 32'd1);

    $display("[TB] zero skip");
    applyStimulus(0, 4'd0, 4'd9, 4'd3, lat, en_n, clr_n);
    checkOutput("lat_skip", 32'(lat), 32'd1);
    checkOutput("z_skip",   32'(obs_z), 32'd0);
    checkOutput("en_skip",  32'(en_n), 32'd0);
    checkOutput("clr_skip", 32'(clr_n), 32'd0);

    $display("[TB] zero without skip");
    applyStimulus(1, 4'd0, 4'd9, 4'd3, lat, en_n, clr_n);
    checkOutput("lat_noskip", 32'(lat), 32'd4099);
    checkOutput("z_noskip",   32'(obs_z), 32'd0);
    checkOutput("en_noskip",  32'(en_n), 32'd4096);

    $display("[TB] backpressure");
    out_ready_t = 1'b0;
    applyStimulus(0, 4'd2, 4'd6, 4'd10, lat, en_n, clr_n);
    checkOutput("z_bp", 32'(obs_z), 32'd120);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      checkOutput("z_bp_hold",     32'(obs_z), 32'd120);
      checkOutput("rdy_bp_hold",   32'(obs_ready), 32'd0);
      checkOutput("valid_bp_hold", 32'(obs_valid), 32'd1);
    end
    checkOutput("dpa_bp_hold", 32'(obs_dp_a), 32'd2);
    out_ready_t = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rdy_bp_release",   32'(obs_ready), 32'd1);
    checkOutput("valid_bp_release", 32'(obs_valid), 32'd0);

    $display("[TB] missing overflow");
    suppress_ov = 1'b1;
    applyStimulus(0, 4'd1, 4'd1, 4'd1, lat, en_n, clr_n);
    checkOutput("z_noov",   32'(obs_z), 32'd1);
    checkOutput("err_noov", 32'(obs_err), 32'd1);
    suppress_ov = 1'b0;
    applyStimulus(0, 4'd1, 4'd2, 4'd3, lat, en_n, clr_n);
    checkOutput("z_after_err",   32'(obs_z), 32'd6);
    checkOutput("err_sticky",    32'(obs_err), 32'd1);

    $display("[TB] reset mid-run");
    sel = 0;
    @(negedge clk);
    for (int g = 0; g < 100 && !obs_ready; g++) @(negedge clk);
    op_a = 4'd3;
    op_b = 4'd5;
    op_c = 4'd7;
    in_valid_t[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_t[0] = 1'b0;
    repeat (1001) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_busy",      32'(obs_busy), 32'd0);
    checkOutput("mid_dp_en",     32'(obs_en), 32'd0);
    checkOutput("mid_dp_a",      32'(obs_dp_a), 32'd0);
    checkOutput("mid_out_valid", 32'(obs_valid), 32'd0);
    checkOutput("mid_z",         32'(obs_z), 32'd0);
    checkOutput("mid_err",       32'(obs_err), 32'd0);
    checkOutput("mid_in_ready",  32'(obs_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("mid_no_result", 32'(obs_valid), 32'd0);
    checkOutput("mid_idle",      32'(obs_busy), 32'd0);

    applyStimulus(0, 4'd3, 4'd5, 4'd7, lat, en_n, clr_n);
    checkOutput("lat_357", 32'(lat), 32'd4099);
    checkOutput("z_357",   32'(obs_z), 32'd105);
    checkOutput("err_357", 32'(obs_err), 32'd0);

    @(posedge clk);
    #1;
    checkOutput("clr_en_overlap", 32'(overlap_cnt), 32'd0);
    checkOutput("en_before_clr",  32'(order_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
